// File: rtl/euler_run_sched.sv
// euler_run_sched: runs a bank of solvers one at a time, timing each and emitting one result record per solver.
// Optional EULER_RUN_SCHED_SUMMARY_EN adds pass_mask / fail_count summary outputs.
module euler_run_sched #(
    parameter int N_PROB = 4,
    parameter int RES_W = 40,
    parameter int CNT_W = 32,
    parameter longint unsigned TIMEOUT = 1000000,
    parameter int RST_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [N_PROB-1:0]       solver_rst,
    input  logic [N_PROB-1:0]       solver_done,
    input  logic [N_PROB-1:0]       solver_error,
    input  logic [N_PROB*RES_W-1:0] solver_result,
    output logic                    busy,
    output logic [3:0]              cur_idx,
    output logic                    res_valid,
    output logic [3:0]              res_idx,
    output logic [RES_W-1:0]        res_value,
    output logic [1:0]              res_status,
    output logic [CNT_W-1:0]        res_cycles,
    output logic                    all_done
`ifdef EULER_RUN_SCHED_SUMMARY_EN
    ,
    output logic [N_PROB-1:0]       pass_mask,
    output logic [4:0]              fail_count
`endif
);
    typedef enum logic [2:0] {IDLE, HOLD, RUN, REPORT, FINISH} state_t;
    state_t state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [N_PROB-1:0] sel;
    logic [RES_W-1:0] slice;
    logic act_done, act_err, hold_end, det, last;
    // select the active solver's signals and derive counter/detection flags
    always_comb begin
        sel = '0;
        slice = '0;
        for (int i = 0; i < N_PROB; i++)
            if (cur_idx == 4'(i)) begin
                sel[i] = 1'b1;
                slice = solver_result[i*RES_W +: RES_W];
            end
        act_done = |(solver_done & sel);
        act_err = |(solver_error & sel);
        cnt_nx = cnt + 1'b1;
        hold_end = cnt_nx == CNT_W'(RST_CYC);
        det = act_err | act_done | (cnt_nx == CNT_W'(TIMEOUT));
        last = cur_idx == 4'(N_PROB - 1);
    end
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;
    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? HOLD : IDLE;
            HOLD:    nxt = hold_end ? RUN : HOLD;
            RUN:     nxt = det ? REPORT : RUN;
            REPORT:  nxt = last ? FINISH : HOLD;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // outputs decoded from state: only the running solver leaves reset
    always_comb begin
        solver_rst = (state == RUN) ? ~sel : '1;
        busy = (state == HOLD) || (state == RUN) || (state == REPORT);
        res_valid = state == REPORT;
    end
    // counter, solver index, record capture and sticky completion flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            cur_idx <= '0;
            res_idx <= '0;
            res_value <= '0;
            res_status <= '0;
            res_cycles <= '0;
            all_done <= 1'b0;
`ifdef EULER_RUN_SCHED_SUMMARY_EN
            pass_mask <= '0;
            fail_count <= '0;
`endif
        end else begin
            cnt <= ((state == HOLD && !hold_end) || state == RUN) ? cnt_nx : '0;
            if (state == IDLE && start) begin
                cur_idx <= '0;
                all_done <= 1'b0;
`ifdef EULER_RUN_SCHED_SUMMARY_EN
                pass_mask <= '0;
                fail_count <= '0;
`endif
            end
            if (state == RUN && det) begin
                res_idx <= cur_idx;
                res_value <= (act_err | act_done) ? slice : '0;
                res_status <= act_err ? 2'b01 : act_done ? 2'b00 : 2'b10;
                res_cycles <= cnt_nx;
`ifdef EULER_RUN_SCHED_SUMMARY_EN
                pass_mask <= pass_mask | ((!act_err && act_done) ? sel : '0);
                fail_count <= fail_count + {4'd0, act_err | ~act_done};
`endif
            end
            if (state == REPORT && !last)
                cur_idx <= cur_idx + 4'd1;
            if (state == FINISH)
                all_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_euler_run_sched.sv
// tb_euler_run_sched: scoreboard bench driving modelled solvers through full passes, timeouts and mid-run reset.
module tb_euler_run_sched;
    localparam int NP = 2;
    localparam int RW = 40;
    localparam int CW = 32;
    localparam int TO = 10;
    typedef struct {
        logic [3:0] idx;
        logic [RW-1:0] v;
        logic [1:0] st;
        logic [CW-1:0] c;
    } rec_t;
    logic clk = 0, rst = 1, start = 0;
    logic [NP-1:0] solver_rst, solver_done, solver_error;
    logic [NP*RW-1:0] solver_result;
    logic busy, res_valid, all_done;
    logic [3:0] cur_idx, res_idx;
    logic [RW-1:0] res_value;
    logic [1:0] res_status;
    logic [CW-1:0] res_cycles;
`ifdef EULER_RUN_SCHED_SUMMARY_EN
    logic [NP-1:0] pass_mask;
    logic [4:0] fail_count;
`endif
    int checks = 0, errors = 0, npulse = 0;
    int done_at [NP];
    int err_at [NP];
    logic [RW-1:0] val [NP];
    logic [NP-1:0] force_done = '0, tog_en = '0;
    logic tog = 0;
    int rc [NP];
    rec_t q [$];

    euler_run_sched #(.N_PROB(NP), .RES_W(RW), .CNT_W(CW), .TIMEOUT(TO), .RST_CYC(2)) dut (
        .clk(clk), .rst(rst), .start(start), .solver_rst(solver_rst),
        .solver_done(solver_done), .solver_error(solver_error), .solver_result(solver_result),
        .busy(busy), .cur_idx(cur_idx), .res_valid(res_valid), .res_idx(res_idx),
        .res_value(res_value), .res_status(res_status), .res_cycles(res_cycles),
        .all_done(all_done)
`ifdef EULER_RUN_SCHED_SUMMARY_EN
        , .pass_mask(pass_mask), .fail_count(fail_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // solver models: count cycles out of reset, raise done/error at programmed run cycle
    always @(posedge clk) begin
        tog <= ~tog;
        for (int i = 0; i < NP; i++) rc[i] <= solver_rst[i] ? 0 : rc[i] + 1;
    end
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            solver_done[i] = force_done[i] | (tog_en[i] & solver_rst[i] & tog) |
                (done_at[i] != 0 && !solver_rst[i] && rc[i] + 1 >= done_at[i]);
            solver_error[i] = (tog_en[i] & solver_rst[i] & ~tog) |
                (err_at[i] != 0 && !solver_rst[i] && rc[i] + 1 >= err_at[i]);
            solver_result[i*RW +: RW] = val[i];
        end
    end

    function automatic rec_t exp_rec(input int i);
        rec_t r;
        int d;
        r.idx = 4'(i);
        r.c = CW'(TO);
        r.st = 2'b10;
        r.v = '0;
        d = force_done[i] ? 1 : done_at[i];
        if (d != 0 && d <= int'(r.c)) begin r.c = CW'(d); r.st = 2'b00; r.v = val[i]; end
        if (err_at[i] != 0 && err_at[i] <= int'(r.c)) begin r.c = CW'(err_at[i]); r.st = 2'b01; r.v = val[i]; end
        return r;
    endfunction

    // scoreboard: every record pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (res_valid) begin
            npulse++;
            if (q.size() == 0) chk("extra_rec", 1, 0);
            else begin
                rec_t e;
                e = q.pop_front();
                chk("res_idx", 64'(res_idx), 64'(e.idx));
                chk("res_value", 64'(res_value), 64'(e.v));
                chk("res_status", 64'(res_status), 64'(e.st));
                chk("res_cycles", 64'(res_cycles), 64'(e.c));
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk) #1 start = 1;
        @(posedge clk) #1 start = 0;
        @(negedge clk);
        chk("busy_on_start", 64'(busy), 1);
        chk("all_done_clr", 64'(all_done), 0);
        chk("cur_idx_start", 64'(cur_idx), 0);
    endtask

    task automatic run_pass(input bit extra_start);
        int n = 0, p0;
        p0 = npulse;
        for (int i = 0; i < NP; i++) q.push_back(exp_rec(i));
        pulse_start();
        if (extra_start) begin
            repeat (3) @(posedge clk);
            #1 start = 1;
            repeat (3) @(posedge clk);
            #1 start = 0;
        end
        while (!all_done && n < 300) begin @(negedge clk); n++; end
        chk("pass_done", 64'(all_done), 1);
        chk("busy_end", 64'(busy), 0);
        chk("queue_empty", 64'(q.size()), 0);
        repeat (4) @(negedge clk);
        chk("pulses", 64'(npulse - p0), 64'(NP));
        chk("all_done_sticky", 64'(all_done), 1);
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin done_at[i] = 0; err_at[i] = 0; val[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_solver_rst", 64'(solver_rst), 64'('1 & 2'b11));
        chk("rst_busy", 64'(busy), 0);
        chk("rst_valid", 64'(res_valid), 0);
        chk("rst_all_done", 64'(all_done), 0);
        chk("rst_cycles", 64'(res_cycles), 0);
        #1 rst = 0;
        // two solvers finishing normally
        done_at[0] = 5; val[0] = 40'd5537376230;
        done_at[1] = 3; val[1] = 40'd42;
        run_pass(0);
        // error and done together; error wins
        done_at[0] = 4; err_at[0] = 4; val[0] = 40'h12_3456_789A;
        done_at[1] = 2; val[1] = 40'd7;
        run_pass(0);
        // solver0 times out; solver1 already done before leaving reset
        done_at[0] = 0; err_at[0] = 0; val[0] = 40'hFF_FFFF_FFFF;
        done_at[1] = 0; force_done[1] = 1; val[1] = 40'd99;
        run_pass(0);
`ifdef EULER_RUN_SCHED_SUMMARY_EN
        chk("pass_mask", 64'(pass_mask), 64'(2'b10));
        chk("fail_count", 64'(fail_count), 1);
`endif
        // reset during solver1's run
        force_done[1] = 0;
        done_at[0] = 3; done_at[1] = 8; val[0] = 40'd1; val[1] = 40'd2;
        q.push_back(exp_rec(0));
        pulse_start();
`ifdef EULER_RUN_SCHED_SUMMARY_EN
        chk("pass_mask_clr", 64'(pass_mask), 0);
        chk("fail_count_clr", 64'(fail_count), 0);
`endif
        begin
            int n = 0;
            while (solver_rst !== 2'b01 && n < 100) begin @(negedge clk); n++; end
        end
        chk("reach_run1", 64'(solver_rst), 64'(2'b01));
        @(posedge clk) #1 rst = 1;
        @(posedge clk) #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_solver_rst", 64'(solver_rst), 64'(2'b11));
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_valid", 64'(res_valid), 0);
        chk("mid_rst_all_done", 64'(all_done), 0);
        chk("mid_rst_cur_idx", 64'(cur_idx), 0);
        chk("mid_rst_status", 64'(res_status), 0);
        chk("queue_after_rst", 64'(q.size()), 0);
        q.delete();
        run_pass(0);
        // start while busy and inactive solver toggling done/error
        done_at[0] = 6; done_at[1] = 2; tog_en = 2'b10; val[0] = 40'd600; val[1] = 40'd200;
        run_pass(1);
        tog_en = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
